// File: rtl/trs80_pkg.sv
// trs80_pkg -- shared types and defaults for the TRS-80 video RAM path.
//   VRAM_AW_DEFAULT : VRAM address width (1 KB video RAM at $3C00-$3FFF)
//   arb_state_t     : VRAM arbiter FSM states
//   grant_t         : which requester won the most recent grant
package trs80_pkg;

   localparam int VRAM_AW_DEFAULT = 10;

   typedef enum logic [2:0] {
      IDLE,
      VID_RD,
      VID_LAT,
      CPU_RD,
      CPU_LAT,
      CPU_WR
   } arb_state_t;

   typedef enum logic {
      GNT_VID,
      GNT_CPU
   } grant_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if -- bundles the three buses around the video RAM arbiter.
//   CPU side   : cpu_vram_cs_n, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_din
//                in; cpu_dout, cpu_wait_n out (arbiter view)
//   video side : vid_req, vid_addr in; vid_ack, vid_data out
//   RAM side   : vram_addr, vram_din, vram_we out; vram_dout in
//   slave modport = arbiter view, master modport = CPU/video/RAM view.
interface vram_arbiter_if #(parameter int AW = trs80_pkg::VRAM_AW_DEFAULT);

   logic          cpu_vram_cs_n;
   logic          cpu_mreq_n;
   logic          cpu_rd_n;
   logic          cpu_wr_n;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din;
   logic [7:0]    cpu_dout;
   logic          cpu_wait_n;

   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack;
   logic [7:0]    vid_data;

   logic [AW-1:0] vram_addr;
   logic [7:0]    vram_din;
   logic          vram_we;
   logic [7:0]    vram_dout;

   modport slave (
      input  cpu_vram_cs_n, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_din,
      output cpu_dout, cpu_wait_n,
      input  vid_req, vid_addr,
      output vid_ack, vid_data,
      output vram_addr, vram_din, vram_we,
      input  vram_dout
   );

   modport master (
      output cpu_vram_cs_n, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_din,
      input  cpu_dout, cpu_wait_n,
      output vid_req, vid_addr,
      input  vid_ack, vid_data,
      input  vram_addr, vram_din, vram_we,
      output vram_dout
   );

endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares a single-port synchronous video RAM between the Z80
// and the video fetch engine. Ties alternate between the two requesters, so
// neither side can starve. One CPU bus cycle maps to exactly one RAM access.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : vram_arbiter_if.slave (CPU strobes/data/WAIT, video req/ack/data,
//             RAM address/data/write enable)
module vram_arbiter
   import trs80_pkg::*;
#(
   parameter int VRAM_AW = VRAM_AW_DEFAULT
) (
   input  logic          clock,
   input  logic          reset_n,
   vram_arbiter_if.slave bus
);

   arb_state_t         state_q, state_d;
   grant_t             last_q, last_d;
   logic               cpu_done_q, cpu_done_d;
   logic               vid_ack_q;
   logic [7:0]         vid_data_q;
   logic [7:0]         cpu_dout_q;
   logic [VRAM_AW-1:0] addr_d;
   logic               we_d;

   logic cpu_req, cpu_wr, cpu_pend;

   assign cpu_req  = !bus.cpu_vram_cs_n && !bus.cpu_mreq_n &&
                     (!bus.cpu_rd_n || !bus.cpu_wr_n);
   assign cpu_wr   = !bus.cpu_wr_n;
   // cpu_done blocks a second access while the Z80 still holds its strobes
   assign cpu_pend = cpu_req && !cpu_done_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      addr_d  = bus.vid_addr;
      we_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // on a tie the side that did not win last time goes first
            if (bus.vid_req && (!cpu_pend || last_q == GNT_CPU)) begin
               state_d = VID_RD;
               last_d  = GNT_VID;
            end else if (cpu_pend) begin
               state_d = cpu_wr ? CPU_WR : CPU_RD;
               last_d  = GNT_CPU;
            end
         end
         VID_RD:  state_d = VID_LAT;
         VID_LAT: state_d = IDLE;
         CPU_RD: begin
            addr_d  = bus.cpu_addr;
            state_d = CPU_LAT;
         end
         CPU_LAT: state_d = IDLE;
         CPU_WR: begin
            addr_d  = bus.cpu_addr;
            we_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Clearing on a low cpu_req wins over setting, so a strobe that drops
   // mid-access finishes the access but leaves no stale done flag behind.
   assign cpu_done_d = cpu_req && (cpu_done_q || state_q == CPU_LAT || state_q == CPU_WR);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_q     <= GNT_CPU;
         cpu_done_q <= 1'b0;
         vid_ack_q  <= 1'b0;
         vid_data_q <= 8'h00;
         cpu_dout_q <= 8'hFF;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         cpu_done_q <= cpu_done_d;
         vid_ack_q  <= (state_q == VID_LAT);
         if (state_q == VID_LAT) vid_data_q <= bus.vram_dout;
         if (state_q == CPU_LAT) cpu_dout_q <= bus.vram_dout;
      end
   end

   assign bus.vram_addr  = addr_d;
   assign bus.vram_din   = bus.cpu_din;
   // gated by reset so a write in flight is killed within the same cycle
   assign bus.vram_we    = we_d && reset_n;
   assign bus.cpu_wait_n = !cpu_pend;
   assign bus.cpu_dout   = cpu_dout_q;
   assign bus.vid_ack    = vid_ack_q;
   assign bus.vid_data   = vid_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- directed checks of vram_arbiter against a behavioural
// synchronous RAM. Inputs change and outputs are sampled 1 ns after the
// rising edge.
module tb_vram_arbiter;
   import trs80_pkg::*;

   localparam int AW = VRAM_AW_DEFAULT;

   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] mem [1 << AW];

   vram_arbiter_if #(.AW(AW)) vif ();

   vram_arbiter #(.VRAM_AW(AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (vif)
   );

   always #5 clock = ~clock;

   // synchronous RAM, one cycle read latency
   always @(posedge clock) begin
      if (vif.vram_we) mem[vif.vram_addr] <= vif.vram_din;
      vif.vram_dout <= mem[vif.vram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic cpu_rel();
      vif.cpu_vram_cs_n = 1'b1;
      vif.cpu_mreq_n    = 1'b1;
      vif.cpu_rd_n      = 1'b1;
      vif.cpu_wr_n      = 1'b1;
   endtask

   task automatic cpu_rd(input logic [AW-1:0] a);
      vif.cpu_addr      = a;
      vif.cpu_vram_cs_n = 1'b0;
      vif.cpu_mreq_n    = 1'b0;
      vif.cpu_rd_n      = 1'b0;
      vif.cpu_wr_n      = 1'b1;
   endtask

   task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d);
      vif.cpu_addr      = a;
      vif.cpu_din       = d;
      vif.cpu_vram_cs_n = 1'b0;
      vif.cpu_mreq_n    = 1'b0;
      vif.cpu_rd_n      = 1'b1;
      vif.cpu_wr_n      = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      cpu_rel();
      vif.cpu_addr = '0;
      vif.cpu_din  = 8'h00;
      vif.vid_req  = 1'b0;
      vif.vid_addr = 10'h005;
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
      mem[10'h005] <= 8'h41;
      mem[10'h010] <= 8'h5A;
      mem[10'h020] <= 8'hC3;
      step(2);

      // reset state
      chk("rst_cpu_dout", vif.cpu_dout, 8'hFF);
      chk("rst_vid_data", vif.vid_data, 8'h00);
      chk("rst_vid_ack",  vif.vid_ack, 1'b0);
      chk("rst_we",       vif.vram_we, 1'b0);
      chk("rst_wait_n",   vif.cpu_wait_n, 1'b1);
      chk("rst_addr",     vif.vram_addr, 10'h005);
      reset_n = 1'b1;
      step(1);

      // video only, request held: ack every 3 cycles
      vif.vid_req = 1'b1;
      step(1);
      chk("vid_rd_addr", vif.vram_addr, 10'h005);
      chk("vid_rd_ack",  vif.vid_ack, 1'b0);
      step(1);
      chk("vid_lat_ack", vif.vid_ack, 1'b0);
      step(1);
      chk("vid_ack1",    vif.vid_ack, 1'b1);
      chk("vid_data1",   vif.vid_data, 8'h41);
      step(1);
      chk("vid_ack_pulse", vif.vid_ack, 1'b0);
      step(1);
      chk("vid_ack_gap", vif.vid_ack, 1'b0);
      step(1);
      chk("vid_ack2",    vif.vid_ack, 1'b1);
      vif.vid_req = 1'b0;
      step(1);

      // CPU write: one wait cycle after the request edge
      cpu_wr(10'h3FF, 8'hAA);
      #1;
      chk("wr_wait_req", vif.cpu_wait_n, 1'b0);
      step(1);
      chk("wr_we",     vif.vram_we, 1'b1);
      chk("wr_addr",   vif.vram_addr, 10'h3FF);
      chk("wr_din",    vif.vram_din, 8'hAA);
      chk("wr_wait",   vif.cpu_wait_n, 1'b0);
      step(1);
      chk("wr_we_off", vif.vram_we, 1'b0);
      chk("wr_done",   vif.cpu_wait_n, 1'b1);
      step(1);
      chk("wr_hold",   vif.cpu_wait_n, 1'b1);
      chk("wr_single", vif.vram_we, 1'b0);
      cpu_rel();
      step(1);
      chk("wr_mem",    mem[10'h3FF], 8'hAA);

      // CPU read: two wait cycles
      cpu_rd(10'h010);
      step(1);
      chk("rd_addr",   vif.vram_addr, 10'h010);
      chk("rd_wait1",  vif.cpu_wait_n, 1'b0);
      step(1);
      chk("rd_wait2",  vif.cpu_wait_n, 1'b0);
      step(1);
      chk("rd_done",   vif.cpu_wait_n, 1'b1);
      chk("rd_dout",   vif.cpu_dout, 8'h5A);
      cpu_rel();
      step(1);

      // strobe drops mid-write: write still commits, no retry
      cpu_wr(10'h066, 8'h99);
      step(1);
      cpu_rel();
      #1;
      chk("drop_we",   vif.vram_we, 1'b1);
      step(1);
      chk("drop_we_off", vif.vram_we, 1'b0);
      step(1);
      chk("drop_mem",  mem[10'h066], 8'h99);
      chk("drop_we_idle", vif.vram_we, 1'b0);
      cpu_rd(10'h066);
      step(3);
      chk("drop_rd_done", vif.cpu_wait_n, 1'b1);
      chk("drop_rd_dout", vif.cpu_dout, 8'h99);
      cpu_rel();
      step(1);

      // reset in the middle of a write
      vif.vid_addr = 10'h0AB;
      cpu_wr(10'h100, 8'h77);
      step(1);
      chk("rstw_we_pre", vif.vram_we, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rstw_we",   vif.vram_we, 1'b0);
      chk("rstw_addr", vif.vram_addr, 10'h0AB);
      chk("rstw_dout", vif.cpu_dout, 8'hFF);
      chk("rstw_ack",  vif.vid_ack, 1'b0);
      cpu_rel();
      step(1);
      reset_n = 1'b1;
      step(1);

      // tie right after reset: video first, then CPU
      vif.vid_addr = 10'h005;
      vif.vid_req  = 1'b1;
      cpu_rd(10'h020);
      step(1);
      chk("tie_vid_addr", vif.vram_addr, 10'h005);
      chk("tie_cpu_wait", vif.cpu_wait_n, 1'b0);
      step(2);
      chk("tie_vid_ack",  vif.vid_ack, 1'b1);
      chk("tie_vid_data", vif.vid_data, 8'h41);
      vif.vid_req = 1'b0;
      step(1);
      chk("tie_cpu_addr", vif.vram_addr, 10'h020);
      step(2);
      chk("tie_cpu_done", vif.cpu_wait_n, 1'b1);
      chk("tie_cpu_dout", vif.cpu_dout, 8'hC3);
      cpu_rel();
      step(1);

      // continuous video with a CPU write: last grant was CPU, so video
      // goes first, then the next tie goes to the CPU, then video again
      vif.vid_req = 1'b1;
      step(1);
      cpu_wr(10'h055, 8'h3C);
      step(2);
      chk("alt_vid_ack",  vif.vid_ack, 1'b1);
      chk("alt_cpu_wait", vif.cpu_wait_n, 1'b0);
      step(1);
      chk("alt_cpu_we",   vif.vram_we, 1'b1);
      chk("alt_cpu_addr", vif.vram_addr, 10'h055);
      chk("alt_cpu_din",  vif.vram_din, 8'h3C);
      step(1);
      chk("alt_cpu_done", vif.cpu_wait_n, 1'b1);
      cpu_rel();
      step(1);
      chk("alt_vid_noack", vif.vid_ack, 1'b0);
      step(2);
      chk("alt_vid_ack2", vif.vid_ack, 1'b1);
      vif.vid_req = 1'b0;
      step(1);
      chk("alt_mem",      mem[10'h055], 8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop in case the sequence above ever stalls
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: VRAM_AW, 10, VRAM address width (1 KB video RAM at $3C00-$3FFF).
REQ-002 clock  in  1  system clock; all state on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 cpu_vram_cs_n  in  1  VRAM chip select from address decode, active low.
REQ-005 cpu_mreq_n / cpu_rd_n / cpu_wr_n  in  1 each  Z80 memory strobes, active low.
REQ-006 cpu_addr  in  VRAM_AW  CPU VRAM offset.
REQ-007 cpu_din  in  8  CPU write data.
REQ-008 cpu_dout  out  8  registered CPU read data.
REQ-009 cpu_wait_n  out  1  Z80 WAIT, active low.
REQ-010 vid_req  in  1  video fetch request, level, held until vid_ack.
REQ-011 vid_addr  in  VRAM_AW  video fetch address, stable while vid_req high.
REQ-012 vid_ack  out  1  one-cycle pulse; vid_data valid.
REQ-013 vid_data  out  8  registered fetched character.
REQ-014 vram_addr  out  VRAM_AW  RAM address.
REQ-015 vram_din  out  8  RAM write data.
REQ-016 vram_we  out  1  RAM write enable, active high.
REQ-017 vram_dout  in  8  RAM read data, synchronous, 1-cycle latency.

Function
REQ-018 cpu_req SHALL be !cpu_vram_cs_n & !cpu_mreq_n & (!cpu_rd_n | !cpu_wr_n); write when !cpu_wr_n, else read.
REQ-019 FSM states SHALL be IDLE, VID_RD, VID_LAT, CPU_RD, CPU_LAT, CPU_WR.
REQ-020 IDLE: only vid_req -> VID_RD; only cpu_req & !cpu_done -> CPU_RD or CPU_WR; neither -> IDLE.
REQ-021 IDLE with both pending: grant the requester not granted last (last_grant flag); update flag on every grant.
REQ-022 VID_RD: vram_addr=vid_addr, vram_we=0; next VID_LAT.
REQ-023 VID_LAT: vid_data<=vram_dout, vid_ack<=1 (pulse visible next cycle); next IDLE.
REQ-024 CPU_RD: vram_addr=cpu_addr; next CPU_LAT. CPU_LAT: cpu_dout<=vram_dout, cpu_done<=1; next IDLE.
REQ-025 CPU_WR: vram_addr=cpu_addr, vram_din=cpu_din, vram_we=1 for exactly one cycle, cpu_done<=1; next IDLE.
REQ-026 vram_we SHALL be 0 in every state except CPU_WR; vram_addr in IDLE = vid_addr.
REQ-027 cpu_wait_n SHALL be combinational: 0 when cpu_req & !cpu_done, else 1.
REQ-028 cpu_done SHALL clear on the first cycle cpu_req is low; one CPU cycle = exactly one VRAM access.
REQ-029 cpu_req dropping mid-access: in-flight access SHALL complete (write committed, read latched); no retry.
REQ-030 Worst-case CPU latency SHALL be one video access plus own access (<= 6 cycles from cpu_req to cpu_wait_n=1); no starvation of either side.
REQ-031 Single access throughput: one access per 3 cycles (grant, latch/complete, IDLE).

Reset
REQ-032 On reset_n low, asynchronously: state=IDLE, last_grant=CPU (video wins first tie), cpu_done=0, vid_ack=0, vid_data=8'h00, cpu_dout=8'hFF; vram_we=0 immediately.
REQ-033 Reset asserted mid-write SHALL force vram_we low in the same cycle; write not guaranteed.

Structure
REQ-034 State enum and VRAM_AW default SHALL live in shared package trs80_pkg.
REQ-035 No sub-module; arbitration, FSM and output registers in one module.

Verification
REQ-036 Video only: vid_req=1, vid_addr=10'h005, RAM[5]=8'h41 -> vid_ack one cycle, vid_data=8'h41, 3 cycles after request; vid_req held -> next ack 3 cycles later.
REQ-037 CPU write: cs/mreq/wr low, addr 10'h3FF, din 8'hAA -> cpu_wait_n low 1 cycle, vram_we pulse with addr 3FF/data AA, cpu_wait_n high until strobes release.
REQ-038 CPU read: RAM[10'h010]=8'h5A -> cpu_wait_n low 2 cycles, cpu_dout=8'h5A, then wait_n=1.
REQ-039 Tie after reset: vid_req and CPU read same cycle -> video granted first, CPU granted immediately after; next tie -> CPU first.
REQ-040 Continuous vid_req with CPU write -> CPU write completes within 6 cycles, grants alternate.
REQ-041 reset_n low during CPU_WR -> vram_we=0 same cycle, state IDLE, cpu_dout=8'hFF, vid_ack=0.
